// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: main game FSM, movement tick, reversal-filtered direction,
// score keeping and LFSR-driven prey placement via the body occupancy check.
module snake_game_ctrl #(
    parameter int unsigned                TICK_WIDTH    = 24,
    parameter logic [TICK_WIDTH-1:0]      TICK_PERIOD   = TICK_WIDTH'(2_500_000),
    parameter int unsigned                H_LOGIC_WIDTH = 5,
    parameter int unsigned                V_LOGIC_WIDTH = 5,
    parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX   = V_LOGIC_WIDTH'(23),
    parameter logic [15:0]                LFSR_SEED     = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_start,
    input  logic [1:0]               key_dir,
    input  logic                     key_vld,
    output logic                     body_rst,
    output logic                     body_enb,
    output logic                     body_valid,
    output logic [1:0]               body_direction,
    input  logic                     body_score,
    input  logic                     body_lose,
    output logic [H_LOGIC_WIDTH-1:0] preyx,
    output logic [V_LOGIC_WIDTH-1:0] preyy,
    output logic                     prey_vld,
    input  logic                     prey_res,
    input  logic                     prey_res_vld,
    output logic [7:0]               score,
    output logic [1:0]               game_state
);

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_MASK = 16'hB400;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] INIT_LAST = 2'd3;
    localparam logic [2:0] WAIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_INIT = 2'b01,
        S_PLAY = 2'b10,
        S_OVER = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        P_IDLE = 2'b00,
        P_REQ  = 2'b01,
        P_WAIT = 2'b10
    } pstate_e;

    state_e                     state_q, state_d;
    pstate_e                    pstate_q, pstate_d;
    logic [1:0]                 init_cnt_q, init_cnt_d;
    logic [2:0]                 wait_cnt_q, wait_cnt_d;
    logic [TICK_WIDTH-1:0]      tick_cnt_q, tick_cnt_d;
    logic [LFSR_WIDTH-1:0]      lfsr_q, lfsr_d;
    logic [1:0]                 cur_dir_q, cur_dir_d;
    logic [1:0]                 pend_dir_q, pend_dir_d;
    logic [7:0]                 score_q, score_d;
    logic [H_LOGIC_WIDTH-1:0]   preyx_q, preyx_d;
    logic [V_LOGIC_WIDTH-1:0]   preyy_q, preyy_d;
    logic                       body_rst_q, body_rst_d;
    logic                       body_valid_q, body_valid_d;
    logic                       prey_vld_q, prey_vld_d;

    logic [V_LOGIC_WIDTH-1:0]   y_raw_c;
    logic [V_LOGIC_WIDTH-1:0]   cand_y_c;
    logic [1:0]                 ref_dir_c;

    // Candidate row folded back into the visible field
    assign y_raw_c  = lfsr_q[H_LOGIC_WIDTH +: V_LOGIC_WIDTH];
    assign cand_y_c = (y_raw_c > V_LOGIC_MAX)
                    ? y_raw_c - V_LOGIC_WIDTH'(V_LOGIC_MAX + 1'b1)
                    : y_raw_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pstate_q     <= P_IDLE;
            init_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            tick_cnt_q   <= '0;
            lfsr_q       <= LFSR_SEED;
            cur_dir_q    <= DIR_RIGHT;
            pend_dir_q   <= DIR_RIGHT;
            score_q      <= '0;
            preyx_q      <= '0;
            preyy_q      <= '0;
            body_rst_q   <= 1'b0;
            body_valid_q <= 1'b0;
            prey_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pstate_q     <= pstate_d;
            init_cnt_q   <= init_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            lfsr_q       <= lfsr_d;
            cur_dir_q    <= cur_dir_d;
            pend_dir_q   <= pend_dir_d;
            score_q      <= score_d;
            preyx_q      <= preyx_d;
            preyy_q      <= preyy_d;
            body_rst_q   <= body_rst_d;
            body_valid_q <= body_valid_d;
            prey_vld_q   <= prey_vld_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pstate_d     = pstate_q;
        init_cnt_d   = init_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        cur_dir_d    = cur_dir_q;
        pend_dir_d   = pend_dir_q;
        score_d      = score_q;
        preyx_d      = preyx_q;
        preyy_d      = preyy_q;
        body_rst_d   = 1'b0;
        body_valid_d = 1'b0;
        prey_vld_d   = 1'b0;
        lfsr_d       = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_MASK : '0);

        // Movement tick, frozen while a prey search is running; a loss kills the step
        if (state_q == S_PLAY && pstate_q == P_IDLE) begin
            if (tick_cnt_q == TICK_PERIOD - TICK_WIDTH'(1)) begin
                tick_cnt_d   = '0;
                body_valid_d = !body_lose;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_WIDTH'(1);
            end
        end

        // Compare against the direction that will be current after this edge
        ref_dir_c = body_valid_d ? pend_dir_q : cur_dir_q;
        if (body_valid_d) begin
            cur_dir_d = pend_dir_q;
        end
        if (key_vld && (key_dir != ~ref_dir_c)) begin
            pend_dir_d = key_dir;
        end

        case (pstate_q)
            P_REQ: begin
                preyx_d    = lfsr_q[H_LOGIC_WIDTH-1:0];
                preyy_d    = cand_y_c;
                prey_vld_d = 1'b1;
                wait_cnt_d = '0;
                pstate_d   = P_WAIT;
            end
            P_WAIT: begin
                if (prey_res_vld) begin
                    pstate_d = prey_res ? P_REQ : P_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    pstate_d = P_REQ;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE, S_OVER: begin
                if (btn_start) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    body_rst_d = 1'b1;
                    score_d    = '0;
                    cur_dir_d  = DIR_RIGHT;
                    pend_dir_d = DIR_RIGHT;
                    pstate_d   = P_IDLE;
                end
            end
            S_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = S_PLAY;
                    tick_cnt_d = '0;
                    pstate_d   = P_REQ;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            S_PLAY: begin
                if (body_lose) begin
                    state_d  = S_OVER;
                    pstate_d = P_IDLE;
                end else if (body_score) begin
                    score_d  = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;
                    pstate_d = P_REQ;
                end
            end
            default: ;
        endcase
    end

    assign body_rst       = body_rst_q;
    assign body_enb       = (state_q == S_INIT) || (state_q == S_PLAY);
    assign body_valid     = body_valid_q;
    assign body_direction = pend_dir_q;
    assign preyx          = preyx_q;
    assign preyy          = preyy_q;
    assign prey_vld       = prey_vld_q;
    assign score          = score_q;
    assign game_state     = state_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl: expected values queued as stimulus is driven,
// popped and asserted when the DUT output is sampled.
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, btn_start, key_vld, body_score, body_lose, prey_res, prey_res_vld;
    logic [1:0] key_dir;
    logic       body_rst, body_enb, body_valid, prey_vld;
    logic [1:0] body_direction, game_state;
    logic [4:0] preyx, preyy;
    logic [7:0] score;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;
    int n;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [15:0] lfsr_m, lfsr_prev;

    always #5 clk = ~clk;

    snake_game_ctrl #(.TICK_PERIOD(24'd8)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .key_dir(key_dir), .key_vld(key_vld),
        .body_rst(body_rst), .body_enb(body_enb), .body_valid(body_valid),
        .body_direction(body_direction), .body_score(body_score), .body_lose(body_lose),
        .preyx(preyx), .preyy(preyy), .prey_vld(prey_vld), .prey_res(prey_res),
        .prey_res_vld(prey_res_vld), .score(score), .game_state(game_state)
    );

    // Reference LFSR; lfsr_prev is the value the DUT saw at the latest edge
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [9:0] cand(input logic [15:0] l);
        logic [4:0] y;
        y = l[9:5];
        if (y > 5'd23) y = y - 5'd24;
        return {l[4:0], y};
    endfunction

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (body_valid) nvalid++;
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!body_valid && cnt < budget);
    endtask

    task automatic wait_prey(input int budget, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!prey_vld && cnt < budget);
    endtask

    task automatic check_reset(input string t);
        push_exp({t, "_state"}, 0);   check(32'(game_state));
        push_exp({t, "_score"}, 0);   check(32'(score));
        push_exp({t, "_enb"}, 0);     check(32'(body_enb));
        push_exp({t, "_dir"}, 1);     check(32'(body_direction));
        push_exp({t, "_prey"}, 0);    check(32'({preyx, preyy}));
        push_exp({t, "_pulses"}, 0);  check(32'({body_valid, body_rst, prey_vld}));
    endtask

    task automatic check_cand(input string t);
        push_exp({t, "_vld"}, 1);            check(32'(prey_vld));
        push_exp({t, "_xy"}, 32'(cand(lfsr_prev)));
        check(32'({preyx, preyy}));
        push_exp({t, "_y_range"}, 1);        check(32'(preyy <= 5'd23));
    endtask

    task automatic reply(input logic occupied);
        prey_res_vld = 1'b1;
        prey_res     = occupied;
        step();
        prey_res_vld = 1'b0;
        prey_res     = 1'b0;
    endtask

    task automatic key(input logic [1:0] d);
        key_dir = d;
        key_vld = 1'b1;
        step();
        key_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_start = 1'b0; key_dir = 2'b00; key_vld = 1'b0;
        body_score = 1'b0; body_lose = 1'b0; prey_res = 1'b0; prey_res_vld = 1'b0;
        step(); step();
        rst = 1'b0;
        check_reset("reset");
        step();

        // Start: body_rst at n+1, INIT for four cycles, PLAY at n+5, prey_vld at n+6
        btn_start = 1'b1; step(); btn_start = 1'b0;
        push_exp("start_body_rst", 1); check(32'(body_rst));
        push_exp("start_init", 1);     check(32'(game_state));
        push_exp("start_enb", 1);      check(32'(body_enb));
        step();
        push_exp("body_rst_pulse", 0); check(32'(body_rst));
        step(); step();
        push_exp("init_n4", 1);        check(32'(game_state));
        step();
        push_exp("play_n5", 2);        check(32'(game_state));
        push_exp("no_prey_vld_n5", 0); check(32'(prey_vld));
        step();
        check_cand("spawn0");
        reply(1'b0);
        nvalid = 0;
        wait_valid(20, n);
        push_exp("tick_first", 8);     check(32'(n));
        push_exp("tick_dir", 1);       check(32'(body_direction));
        wait_valid(20, n);
        push_exp("tick_period", 8);    check(32'(n));

        // Reversal filter
        key(2'b10);
        push_exp("rev_left_drop", 1);  check(32'(body_direction));
        key(2'b00);
        push_exp("key_up_accept", 0);  check(32'(body_direction));
        wait_valid(20, n);
        push_exp("tick_after_keys", 6); check(32'(n));
        key(2'b11);
        push_exp("rev_down_drop", 0);  check(32'(body_direction));
        key(2'b01);
        push_exp("key_right_accept", 1); check(32'(body_direction));
        wait_valid(20, n);
        push_exp("tick_after_keys2", 6); check(32'(n));

        // Score plus occupied retries and a timed-out reply
        body_score = 1'b1; step(); body_score = 1'b0;
        push_exp("score_one", 1);      check(32'(score));
        nvalid = 0;
        step();
        check_cand("spawn_a");
        for (int r = 0; r < 2; r++) begin
            reply(1'b1);
            step();
            check_cand("spawn_retry");
        end
        wait_prey(20, n);
        push_exp("timeout_gap", 9);    check(32'(n));
        check_cand("spawn_timeout");
        reply(1'b0);
        push_exp("no_valid_in_search", 0); check(32'(nvalid));

        // Saturation
        for (int i = 2; i <= 255; i++) begin
            body_score = 1'b1; step(); body_score = 1'b0;
            step();
            reply(1'b0);
        end
        push_exp("score_255", 255);    check(32'(score));
        body_score = 1'b1; step(); body_score = 1'b0;
        push_exp("score_sat", 255);    check(32'(score));
        step();
        reply(1'b0);

        // Lose beats score in the same cycle
        key(2'b00);
        push_exp("pre_lose_dir", 0);   check(32'(body_direction));
        body_lose = 1'b1; body_score = 1'b1; step();
        body_lose = 1'b0; body_score = 1'b0;
        push_exp("lose_state", 3);     check(32'(game_state));
        push_exp("lose_score", 255);   check(32'(score));
        push_exp("lose_enb", 0);       check(32'(body_enb));
        nvalid = 0;
        for (int i = 0; i < 12; i++) step();
        push_exp("over_no_valid", 0);  check(32'(nvalid));

        // Restart from OVER
        btn_start = 1'b1; step(); btn_start = 1'b0;
        push_exp("restart_body_rst", 1); check(32'(body_rst));
        push_exp("restart_score", 0);  check(32'(score));
        push_exp("restart_dir", 1);    check(32'(body_direction));
        push_exp("restart_init", 1);   check(32'(game_state));

        // Reset in the middle of a spawn
        for (int i = 0; i < 4; i++) step();
        push_exp("restart_play", 2);   check(32'(game_state));
        step();
        check_cand("spawn_restart");
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check_reset("midspawn_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
